// File: rtl/complex_pkg.sv
// Shared definitions for the complex arithmetic blocks: AXI-stream width
// helper, controller state encoding and tuser flag positions.
package complex_pkg;

    // Controller states of the complex divider
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_SUM,
        ST_PREP,
        ST_DIV,
        ST_OUT
    } state_t;

    // tuser flag positions on the result stream
    localparam int unsigned TUSER_DZ  = 0;
    localparam int unsigned TUSER_SAT = 1;

    // Byte-friendly AXI-stream width holding a real/imag pair of width w
    function automatic int unsigned axis_width(input int unsigned w);
        return ((2 * w + 15) / 16) * 16;
    endfunction

endpackage

// File: rtl/unsigned_restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// A start pulse loads the dividend and aligns the divisor under the top
// quotient bit; done rises once all quotient bits have been resolved and
// stays high until the next start.
module unsigned_restoring_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 47,
    parameter int unsigned DIVISOR_WIDTH  = 33,
    parameter int unsigned QUOTIENT_BITS  = 15
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic [QUOTIENT_BITS-1:0]  quotient_o,
    output logic                      done_o
);

    localparam int unsigned R_W   = (DIVIDEND_WIDTH > DIVISOR_WIDTH + QUOTIENT_BITS) ?
                                    DIVIDEND_WIDTH : DIVISOR_WIDTH + QUOTIENT_BITS;
    localparam int unsigned CNT_W = $clog2(QUOTIENT_BITS + 1);

    logic [R_W-1:0]           rem_q;
    logic [R_W-1:0]           dsh_q;
    logic [QUOTIENT_BITS-1:0] quot_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     ge_d;
    logic [R_W-1:0]           rem_sub_d;

    // Trial subtraction of the shifted divisor from the running remainder
    always_comb begin
        ge_d      = (rem_q >= dsh_q);
        rem_sub_d = rem_q - dsh_q;
    end

    // Iteration registers: load on start, then one compare-subtract per cycle
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= R_W'(dividend_i);
            dsh_q  <= R_W'(divisor_i) << (QUOTIENT_BITS - 1);
            quot_q <= '0;
            cnt_q  <= CNT_W'(QUOTIENT_BITS - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            if (ge_d) begin
                rem_q <= rem_sub_d;
            end
            quot_q <= (quot_q << 1) | QUOTIENT_BITS'(ge_d);
            dsh_q  <= dsh_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign quotient_o = quot_q;
    assign done_o     = done_q;

endmodule

// File: rtl/complex_divider.sv
// Sequential fixed-point complex divider q = a / b over AXI-stream.
// Operands are taken jointly from two slave streams, the conjugate products
// are formed and summed, then real and imag magnitudes are divided by
// |b|^2 in two parallel restoring dividers. One operation in flight;
// result latency is OUTPUT_WIDTH+3 cycles from the accepting edge.
module complex_divider
    import complex_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 16,
    parameter int unsigned OUTPUT_WIDTH  = 16,
    parameter int unsigned FRAC_BITS     = 14
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [axis_width(OPERAND_WIDTH)-1:0]  s_axis_a_tdata,
    input  logic                                  s_axis_a_tvalid,
    output logic                                  s_axis_a_tready,
    input  logic [axis_width(OPERAND_WIDTH)-1:0]  s_axis_b_tdata,
    input  logic                                  s_axis_b_tvalid,
    output logic                                  s_axis_b_tready,
    output logic [axis_width(OUTPUT_WIDTH)-1:0]   m_axis_dout_tdata,
    output logic [1:0]                            m_axis_dout_tuser,
    output logic                                  m_axis_dout_tvalid,
    input  logic                                  m_axis_dout_tready
);

    localparam int unsigned W        = OPERAND_WIDTH;
    localparam int unsigned OW       = OUTPUT_WIDTH;
    localparam int unsigned IN_HALF  = axis_width(W) / 2;
    localparam int unsigned OUT_W    = axis_width(OW);
    localparam int unsigned OUT_HALF = OUT_W / 2;
    localparam int unsigned P_W      = 2 * W;
    localparam int unsigned S_W      = 2 * W + 1;
    localparam int unsigned Q_BITS   = OW - 1;
    localparam int unsigned SAT_SH   = OW - 1 - FRAC_BITS;
    localparam int unsigned CMP_W    = S_W + SAT_SH + 1;
    localparam int unsigned DVD_W    = S_W + FRAC_BITS;

    localparam logic signed [OW-1:0] Q_MAX = {1'b0, {(OW-1){1'b1}}};

    // Control and registered outputs
    state_t               state_q;
    logic                 s_ready_q;
    logic                 m_valid_q;
    logic [OUT_W-1:0]     m_data_q;
    logic [1:0]           m_user_q;

    // Datapath pipeline
    logic signed [W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic signed [P_W-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q, p_br2_q, p_bi2_q;
    logic signed [S_W-1:0] num_r_q, num_i_q;
    logic [S_W-1:0]        den_q;
    logic                  neg_r_q, neg_i_q, sat_r_q, sat_i_q, dz_q;

    // Combinational helpers
    logic                  accept_d;
    logic                  div_start_d;
    logic [S_W-1:0]        mag_r_d, mag_i_d;
    logic                  sat_r_d, sat_i_d;
    logic [DVD_W-1:0]      dvd_r_d, dvd_i_d;
    logic signed [OW-1:0]  q_ext_r_d, q_ext_i_d;
    logic signed [OW-1:0]  res_r_d, res_i_d;
    logic [OUT_W-1:0]      data_d;
    logic [1:0]            user_d;

    // Divider outputs
    logic [Q_BITS-1:0]     quo_r, quo_i;
    logic                  done_r, done_i;

    assign accept_d    = (state_q == ST_IDLE) && s_ready_q && s_axis_a_tvalid && s_axis_b_tvalid;
    assign div_start_d = (state_q == ST_PREP);

    // Magnitude, saturation test and scaled dividend for each component
    always_comb begin
        mag_r_d = num_r_q[S_W-1] ? $unsigned(-num_r_q) : $unsigned(num_r_q);
        mag_i_d = num_i_q[S_W-1] ? $unsigned(-num_i_q) : $unsigned(num_i_q);
        sat_r_d = (CMP_W'(mag_r_d) >= (CMP_W'(den_q) << SAT_SH));
        sat_i_d = (CMP_W'(mag_i_d) >= (CMP_W'(den_q) << SAT_SH));
        dvd_r_d = DVD_W'(mag_r_d) << FRAC_BITS;
        dvd_i_d = DVD_W'(mag_i_d) << FRAC_BITS;
    end

    // Final signed, saturated result and flag word
    always_comb begin
        q_ext_r_d = {1'b0, quo_r};
        q_ext_i_d = {1'b0, quo_i};
        user_d    = '0;
        if (sat_r_q) begin
            res_r_d = neg_r_q ? -Q_MAX : Q_MAX;
        end else begin
            res_r_d = neg_r_q ? -q_ext_r_d : q_ext_r_d;
        end
        if (sat_i_q) begin
            res_i_d = neg_i_q ? -Q_MAX : Q_MAX;
        end else begin
            res_i_d = neg_i_q ? -q_ext_i_d : q_ext_i_d;
        end
        if (dz_q) begin
            res_r_d          = '0;
            res_i_d          = '0;
            user_d[TUSER_DZ] = 1'b1;
        end else begin
            user_d[TUSER_SAT] = sat_r_q | sat_i_q;
        end
        data_d = {OUT_HALF'(res_i_d), OUT_HALF'(res_r_d)};
    end

    // Operand capture, product and sum stages, advanced by controller state
    always_ff @(posedge aclk) begin
        if (accept_d) begin
            ar_q <= s_axis_a_tdata[W-1:0];
            ai_q <= s_axis_a_tdata[IN_HALF +: W];
            br_q <= s_axis_b_tdata[W-1:0];
            bi_q <= s_axis_b_tdata[IN_HALF +: W];
        end
        if (state_q == ST_MULT) begin
            p_rr_q  <= P_W'(ar_q) * P_W'(br_q);
            p_ii_q  <= P_W'(ai_q) * P_W'(bi_q);
            p_ir_q  <= P_W'(ai_q) * P_W'(br_q);
            p_ri_q  <= P_W'(ar_q) * P_W'(bi_q);
            p_br2_q <= P_W'(br_q) * P_W'(br_q);
            p_bi2_q <= P_W'(bi_q) * P_W'(bi_q);
        end
        if (state_q == ST_SUM) begin
            num_r_q <= S_W'(p_rr_q) + S_W'(p_ii_q);
            num_i_q <= S_W'(p_ir_q) - S_W'(p_ri_q);
            den_q   <= {1'b0, p_br2_q} + {1'b0, p_bi2_q};
        end
    end

    // Transaction controller with registered handshake and result outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            neg_r_q   <= 1'b0;
            neg_i_q   <= 1'b0;
            sat_r_q   <= 1'b0;
            sat_i_q   <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        s_ready_q <= 1'b0;
                        state_q   <= ST_MULT;
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                ST_MULT: state_q <= ST_SUM;
                ST_SUM:  state_q <= ST_PREP;
                ST_PREP: begin
                    neg_r_q <= num_r_q[S_W-1];
                    neg_i_q <= num_i_q[S_W-1];
                    sat_r_q <= sat_r_d;
                    sat_i_q <= sat_i_d;
                    dz_q    <= (den_q == '0);
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    if (done_r && done_i) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= data_d;
                        m_user_q  <= user_d;
                        state_q   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_axis_dout_tready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    unsigned_restoring_divider #(
        .DIVIDEND_WIDTH (DVD_W),
        .DIVISOR_WIDTH  (S_W),
        .QUOTIENT_BITS  (Q_BITS)
    ) u_div_re (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start_i    (div_start_d),
        .dividend_i (dvd_r_d),
        .divisor_i  (den_q),
        .quotient_o (quo_r),
        .done_o     (done_r)
    );

    unsigned_restoring_divider #(
        .DIVIDEND_WIDTH (DVD_W),
        .DIVISOR_WIDTH  (S_W),
        .QUOTIENT_BITS  (Q_BITS)
    ) u_div_im (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start_i    (div_start_d),
        .dividend_i (dvd_i_d),
        .divisor_i  (den_q),
        .quotient_o (quo_i),
        .done_o     (done_i)
    );

    assign s_axis_a_tready    = s_ready_q;
    assign s_axis_b_tready    = s_ready_q;
    assign m_axis_dout_tvalid = m_valid_q;
    assign m_axis_dout_tdata  = m_data_q;
    assign m_axis_dout_tuser  = m_user_q;

endmodule

// File: tb/tb_complex_divider.sv
// Scoreboard bench for complex_divider with default parameters.
// Accepted operand pairs are turned into expected results by an arithmetic
// reference model; a monitor compares every output transfer, its latency,
// and output stability under backpressure.
module tb_complex_divider;

    localparam int unsigned OW  = 16;
    localparam int unsigned F   = 14;
    localparam int          LAT = OW + 3;
    localparam longint      QMAX = (longint'(1) << (OW - 1)) - 1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] a_tdata = '0, b_tdata = '0;
    logic        a_tvalid = 1'b0, b_tvalid = 1'b0;
    logic        a_tready, b_tready;
    logic [31:0] dout;
    logic [1:0]  tuser;
    logic        dvalid;
    logic        dready = 1'b1;

    always #5 aclk = ~aclk;

    complex_divider #(
        .OPERAND_WIDTH (16),
        .OUTPUT_WIDTH  (16),
        .FRAC_BITS     (14)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_a_tdata     (a_tdata),
        .s_axis_a_tvalid    (a_tvalid),
        .s_axis_a_tready    (a_tready),
        .s_axis_b_tdata     (b_tdata),
        .s_axis_b_tvalid    (b_tvalid),
        .s_axis_b_tready    (b_tready),
        .m_axis_dout_tdata  (dout),
        .m_axis_dout_tuser  (tuser),
        .m_axis_dout_tvalid (dvalid),
        .m_axis_dout_tready (dready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  user;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_rdy = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string info);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    // q = trunc(num * 2^F / den) per component, clipped to +/-QMAX
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t   e;
        longint ar, ai, br, bi, nr, ni, den, qr, qi;
        bit     sat;
        ar  = $signed(a[15:0]);
        ai  = $signed(a[31:16]);
        br  = $signed(b[15:0]);
        bi  = $signed(b[31:16]);
        nr  = ar * br + ai * bi;
        ni  = ai * br - ar * bi;
        den = br * br + bi * bi;
        e.acc = acc;
        sat   = 1'b0;
        if (den == 0) begin
            e.data = '0;
            e.user = 2'b01;
        end else begin
            qr = (nr * (longint'(1) << F)) / den;
            qi = (ni * (longint'(1) << F)) / den;
            if (qr > QMAX) begin qr = QMAX; sat = 1'b1; end
            else if (qr < -QMAX) begin qr = -QMAX; sat = 1'b1; end
            if (qi > QMAX) begin qi = QMAX; sat = 1'b1; end
            else if (qi < -QMAX) begin qi = -QMAX; sat = 1'b1; end
            e.data = {qi[15:0], qr[15:0]};
            e.user = {sat, 1'b0};
        end
        return e;
    endfunction

    // Monitor: record accepts, check latency, stability and each transfer
    bit          pending = 0;
    logic [31:0] held_d;
    logic [1:0]  held_u;
    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            exp_q.delete();
            pending = 0;
        end else begin
            if (a_tvalid && b_tvalid && a_tready && b_tready) begin
                check(!dvalid, "accept_during_output", $sformatf("tvalid=%0b required 0", dvalid));
                exp_q.push_back(ref_model(a_tdata, b_tdata, cyc + 1));
            end
            if (pending) begin
                check(dvalid, "valid_held", $sformatf("tvalid=%0b required 1 until transfer", dvalid));
                if (dvalid)
                    check(dout == held_d && tuser == held_u, "stable",
                          $sformatf("data=%h user=%b required data=%h user=%b", dout, tuser, held_d, held_u));
            end else if (dvalid) begin
                if (exp_q.size() == 0)
                    check(0, "unexpected_output", $sformatf("data=%h with no pending operation", dout));
                else
                    check(cyc - exp_q[0].acc == LAT, "latency",
                          $sformatf("got %0d cycles required %0d", cyc - exp_q[0].acc, LAT));
                check(!a_tready && !b_tready, "ready_during_output",
                      $sformatf("a_tready=%0b b_tready=%0b required 0", a_tready, b_tready));
            end
            if (dvalid && dready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(dout == e.data && tuser == e.user, "result",
                      $sformatf("got data=%h user=%b required data=%h user=%b", dout, tuser, e.data, e.user));
            end
            pending = dvalid && !dready;
            held_d  = dout;
            held_u  = tuser;
        end
    end

    // Random downstream backpressure during the randomized phase
    always @(posedge aclk) begin
        if (rand_rdy) begin
            #1;
            dready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic signed [15:0] ar, input logic signed [15:0] ai,
                        input logic signed [15:0] br, input logic signed [15:0] bi);
        bit ok;
        a_tdata  = {ai, ar};
        b_tdata  = {bi, br};
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge aclk);
            if (a_tready && b_tready) ok = 1;
            @(posedge aclk);
            #1;
        end
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        if (!ok) check(0, "accept_timeout", "operands not accepted within 300 cycles");
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && !dvalid) done = 1;
        end
        check(done, "drain_timeout", $sformatf("%0d results still outstanding", exp_q.size()));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bit seen;
        logic signed [15:0] ar, ai, br, bi;

        // Reset state and ready release
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check(!dvalid && dout == '0 && tuser == '0 && !a_tready && !b_tready, "reset_outputs",
              $sformatf("tvalid=%0b data=%h user=%b ready=%0b%0b required all 0", dvalid, dout, tuser, a_tready, b_tready));
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check(!a_tready && !b_tready, "ready_before_first_clock",
              $sformatf("ready=%0b%0b required 00", a_tready, b_tready));
        @(negedge aclk);
        check(a_tready && b_tready, "ready_after_release",
              $sformatf("ready=%0b%0b required 11", a_tready, b_tready));
        @(posedge aclk);
        #1;

        // Directed values, including divide-by-zero, saturation and rounding
        send(16'sd16384, 16'sd0, 16'sd16384, 16'sd0);
        send(16'sd16384, 16'sd0, 16'sd0, 16'sd16384);
        send(16'sd0, 16'sd16384, 16'sd0, 16'sd16384);
        send(16'sd16384, 16'sd0, 16'sd0, 16'sd0);
        send(16'sd32767, 16'sd0, 16'sd1, 16'sd0);
        send(16'sh8000, 16'sd0, 16'sd1, 16'sd0);
        send(16'sd16384, 16'sd0, -16'sd16383, 16'sd0);
        send(16'sd0, 16'sd0, 16'sd123, -16'sd456);
        send(-16'sd1000, 16'sd2500, 16'sd3000, -16'sd4000);
        wait_idle();

        // A lone valid on either stream must not be consumed
        a_tvalid = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            check(a_tready && b_tready, "single_a_not_consumed",
                  $sformatf("ready=%0b%0b required 11", a_tready, b_tready));
        end
        @(posedge aclk);
        #1 a_tvalid = 1'b0; b_tvalid = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            check(a_tready && b_tready, "single_b_not_consumed",
                  $sformatf("ready=%0b%0b required 11", a_tready, b_tready));
        end
        @(posedge aclk);
        #1 b_tvalid = 1'b0;

        // Backpressure: result held, inputs blocked, next pair waits
        dready = 1'b0;
        send(16'sd1000, -16'sd2000, 16'sd3000, 16'sd4000);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge aclk);
            if (dvalid) seen = 1;
        end
        check(seen, "tvalid_timeout", "no result within 40 cycles");
        @(posedge aclk);
        #1;
        a_tdata  = {16'sd7000, -16'sd9000};
        b_tdata  = {-16'sd200, 16'sd150};
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            check(!a_tready && !b_tready, "ready_low_while_stalled",
                  $sformatf("ready=%0b%0b required 00", a_tready, b_tready));
        end
        @(posedge aclk);
        #1 dready = 1'b1;
        send(-16'sd9000, 16'sd7000, 16'sd150, -16'sd200);
        wait_idle();

        // Reset during division discards the operation
        send(16'sd12345, -16'sd321, 16'sd2222, 16'sd777);
        repeat (8) @(posedge aclk);
        #1 aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check(!a_tready && !b_tready && !dvalid, "state_after_reset",
              $sformatf("ready=%0b%0b tvalid=%0b required 000", a_tready, b_tready, dvalid));
        @(negedge aclk);
        check(a_tready && b_tready, "ready_after_mid_reset",
              $sformatf("ready=%0b%0b required 11", a_tready, b_tready));
        @(posedge aclk);
        #1;
        send(16'sd16384, 16'sd0, 16'sd0, 16'sd16384);
        wait_idle();

        // Randomized operands with random downstream backpressure
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            ar = 16'($urandom);
            ai = 16'($urandom);
            br = 16'($urandom);
            bi = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin ar = ar >>> 6; ai = ai >>> 6; end
                1: bi = '0;
                2: begin br = br >>> 10; bi = bi >>> 10; end
                3: if ($urandom_range(0, 2) == 0) begin br = '0; bi = '0; end
                default: ;
            endcase
            send(ar, ai, br, bi);
        end
        wait_idle();
        rand_rdy = 0;
        @(posedge aclk);
        #2 dready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
